obuft_burst_drive: RTL and testbench

Parametrised tristate output bank controller: accepts data bursts on a valid/ready stream and drives them onto a WIDTH-bit tristate pad group framed by programmable preamble/postamble patterns, followed by a mandatory high-Z turnaround gap. Output enable is registered on the falling clock edge so that it brackets the driven data by half a cycle on each side. Sits between fabric logic and a bank of OBUFT primitives; `out_q`/`out_t` connect directly to each OBUFT's I/T pins.

---
 rtl/obuft_drive_pkg.sv | 24 ++
 rtl/obuft_t_negreg.sv | 17 +
 rtl/obuft_burst_drive.sv | 148 ++++++++++++++
 tb/tb_obuft_burst_drive.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/obuft_drive_pkg.sv
// Shared types and sizing helpers for the OBUFT burst driver.
package obuft_drive_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_DATA = 3'd2,
    ST_POST = 3'd3,
    ST_TURN = 3'd4
  } drive_state_t;

  // Counter width large enough to hold the longest phase length.
  function automatic int unsigned cnt_width(input int unsigned pre,
                                            input int unsigned post,
                                            input int unsigned gap);
    int unsigned m;
    m = pre;
    if (post > m) m = post;
    if (gap > m) m = gap;
    if (m < 1) m = 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/obuft_t_negreg.sv
// Falling-edge tristate-control register, one bit replicated across the bank.
module obuft_t_negreg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             t_d,
  output logic [WIDTH-1:0] t_q
);

  // Reset parks the pads in high-Z; otherwise capture on the falling edge.
  always_ff @(negedge clkin or negedge rst_n) begin
    if (!rst_n) t_q <= '1;
    else        t_q <= {WIDTH{t_d}};
  end

endmodule

// File: rtl/obuft_burst_drive.sv
// Drives valid/ready bursts onto a tristate pad group with preamble,
// postamble and a high-Z turnaround gap.
module obuft_burst_drive
  import obuft_drive_pkg::*;
#(
  parameter int unsigned      WIDTH        = 8,
  parameter int unsigned      PRE_CYCLES   = 1,
  parameter int unsigned      POST_CYCLES  = 1,
  parameter int unsigned      GAP_CYCLES   = 2,
  parameter logic [WIDTH-1:0] PRE_PATTERN  = '0,
  parameter logic [WIDTH-1:0] POST_PATTERN = '0
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic [WIDTH-1:0] out_q,
  output logic [WIDTH-1:0] out_t,
  output logic             busy,
  output logic             underrun
);

  localparam int unsigned CW = cnt_width(PRE_CYCLES, POST_CYCLES, GAP_CYCLES);
  localparam logic [CW-1:0] PRE_LOAD  = CW'(PRE_CYCLES - 1);
  localparam logic [CW-1:0] POST_LOAD = CW'((POST_CYCLES > 0) ? POST_CYCLES - 1 : 0);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

  // Reject lengths the sequencing cannot represent.
  if (PRE_CYCLES == 0) begin : g_pre_chk
    $error("obuft_burst_drive: PRE_CYCLES must be >= 1");
  end
  if (GAP_CYCLES == 0) begin : g_gap_chk
    $error("obuft_burst_drive: GAP_CYCLES must be >= 1");
  end

  drive_state_t     state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] q_d;
  logic             underrun_d;
  logic             t_next;

  function automatic logic is_drive(input drive_state_t s);
    return (s == ST_PRE) || (s == ST_DATA) || (s == ST_POST);
  endfunction

  // Ready depends only on registered state so it never loops back through s_valid.
  assign s_ready = ((state_q == ST_PRE) && (cnt_q == '0)) ||
                   ((state_q == ST_DATA) && !last_q);
  assign busy    = (state_q != ST_IDLE);

  // Next-state, next pad value and underrun detection.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    q_d        = out_q;
    underrun_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        q_d = '0;
        if (s_valid) begin
          state_d = ST_PRE;
          q_d     = PRE_PATTERN;
          cnt_d   = PRE_LOAD;
        end
      end
      ST_PRE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (s_valid) begin
          state_d = ST_DATA;
          q_d     = s_data;
          last_d  = s_last;
        end
      end
      ST_DATA: begin
        if (last_q) begin
          last_d = 1'b0;
          if (POST_CYCLES > 0) begin
            state_d = ST_POST;
            q_d     = POST_PATTERN;
            cnt_d   = POST_LOAD;
          end else begin
            state_d = ST_TURN;
            q_d     = '0;
            cnt_d   = GAP_LOAD;
          end
        end else if (s_valid) begin
          q_d    = s_data;
          last_d = s_last;
        end else begin
          underrun_d = 1'b1;
        end
      end
      ST_POST: begin
        if (cnt_q == '0) begin
          state_d = ST_TURN;
          q_d     = '0;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_TURN: begin
        q_d = '0;
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: begin
        state_d = ST_IDLE;
        q_d     = '0;
        cnt_d   = '0;
        last_d  = 1'b0;
      end
    endcase
  end

  // Enable spans both the current and the upcoming cycle so it brackets data by half a cycle.
  assign t_next = ~(is_drive(state_q) | is_drive(state_d));

  // Rising-edge state and pad data registers.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b0;
      out_q    <= '0;
      underrun <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      out_q    <= q_d;
      underrun <= underrun_d;
    end
  end

  obuft_t_negreg #(.WIDTH(WIDTH)) u_t_reg (
    .clkin (clkin),
    .rst_n (rst_n),
    .t_d   (t_next),
    .t_q   (out_t)
  );

endmodule

// File: tb/tb_obuft_burst_drive.sv
// Bench for obuft_burst_drive: vector table, corner sequences and a random
// run against a burst-timeline reference model.
module tb_obuft_burst_drive;

  localparam int PRE  = 2;
  localparam int POST = 1;
  localparam int GAP  = 2;
  localparam logic [7:0] PRE_PAT  = 8'hAA;
  localparam logic [7:0] POST_PAT = 8'h55;

  logic       clkin = 1'b0;
  logic       rst_n;
  logic       s_valid, s_last, s_ready, busy, underrun;
  logic [7:0] s_data, out_q, out_t;
  logic       v0, l0, r0, b0, u0;
  logic [7:0] d0, q0, t0;

  int checks = 0;
  int errors = 0;

  always #5 clkin = ~clkin;

  obuft_burst_drive #(
    .WIDTH(8), .PRE_CYCLES(PRE), .POST_CYCLES(POST), .GAP_CYCLES(GAP),
    .PRE_PATTERN(PRE_PAT), .POST_PATTERN(POST_PAT)
  ) dut (
    .clkin(clkin), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .out_q(out_q), .out_t(out_t),
    .busy(busy), .underrun(underrun)
  );

  obuft_burst_drive #(
    .WIDTH(8), .PRE_CYCLES(PRE), .POST_CYCLES(0), .GAP_CYCLES(GAP),
    .PRE_PATTERN(PRE_PAT), .POST_PATTERN(POST_PAT)
  ) dut0 (
    .clkin(clkin), .rst_n(rst_n), .s_valid(v0), .s_ready(r0),
    .s_data(d0), .s_last(l0), .out_q(q0), .out_t(t0),
    .busy(b0), .underrun(u0)
  );

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       l;
    logic       rdy;   // s_ready during the cycle before the edge
    logic [7:0] t;     // out_t at the falling edge before the edge
    logic [7:0] q;     // out_q after the edge
    logic       b;
    logic       u;
  } vec_t;

  vec_t tbl[$];

  // Reference model: burst timeline measured in rising-edge numbers.
  int         n, st, acc, last_e;
  bit         in_b, und_m;
  logic [7:0] lastw;

  function automatic vec_t mk(logic v, logic [7:0] d, logic l, logic rdy,
                              logic [7:0] t, logic [7:0] q, logic b, logic u);
    vec_t r;
    r.v = v; r.d = d; r.l = l; r.rdy = rdy; r.t = t; r.q = q; r.b = b; r.u = u;
    return r;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return in_b && (last_e < 0) && (acc > 0 || (n + 1) - st >= PRE);
  endfunction

  function automatic bit m_drive();
    return in_b && (last_e < 0 || n < last_e + 1 + POST);
  endfunction

  function automatic logic [7:0] m_t(input logic v);
    bit nxt;
    if (!in_b)           nxt = v;
    else if (last_e < 0) nxt = 1'b1;
    else                 nxt = (n + 1 < last_e + 1 + POST);
    return (m_drive() || nxt) ? 8'h00 : 8'hFF;
  endfunction

  function automatic logic [7:0] m_q();
    if (!in_b)                          return 8'h00;
    if (acc == 0)                       return PRE_PAT;
    if (last_e < 0 || n <= last_e)      return lastw;
    if (n - last_e <= POST)             return POST_PAT;
    return 8'h00;
  endfunction

  task automatic m_step(input logic v, input logic [7:0] d, input logic l);
    n++;
    und_m = 1'b0;
    if (!in_b) begin
      if (v) begin in_b = 1'b1; st = n; acc = 0; last_e = -1; end
    end else if (last_e < 0) begin
      if ((acc > 0 || n - st >= PRE) && v) begin
        acc++; lastw = d;
        if (l) last_e = n;
      end else if (acc > 0 && !v) begin
        und_m = 1'b1;
      end
    end else if (n >= last_e + 1 + POST + GAP) begin
      in_b = 1'b0;
    end
  endtask

  task automatic do_reset();
    s_valid = 0; s_data = 0; s_last = 0; v0 = 0; d0 = 0; l0 = 0;
    rst_n = 1'b0;
    #1;
    chk("rst_q", out_q, 8'h00);
    chk("rst_t", out_t, 8'hFF);
    chk("rst_busy", 8'(busy), 8'h00);
    chk("rst_und", 8'(underrun), 8'h00);
    chk("rst_q0", q0, 8'h00);
    chk("rst_t0", t0, 8'hFF);
    @(negedge clkin);
    rst_n = 1'b1;
    @(posedge clkin);
    #1;
    in_b = 0; n = 0; st = 0; acc = 0; last_e = -1; und_m = 0; lastw = 0;
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, input logic l);
    s_valid = v; s_data = d; s_last = l;
    @(posedge clkin);
    #1;
  endtask

  logic [7:0] h_q [0:5];
  logic [7:0] h_t [0:5];
  logic       h_b [0:5];

  initial begin
    rst_n = 1'b1;
    s_valid = 0; s_data = 0; s_last = 0; v0 = 0; d0 = 0; l0 = 0;

    // Three-word burst, underrun stall, and s_valid held through the gap.
    tbl.push_back(mk(1, 8'h11, 0, 0, 8'h00, 8'hAA, 1, 0));
    tbl.push_back(mk(1, 8'h11, 0, 0, 8'h00, 8'hAA, 1, 0));
    tbl.push_back(mk(1, 8'h11, 0, 1, 8'h00, 8'h11, 1, 0));
    tbl.push_back(mk(1, 8'h22, 0, 1, 8'h00, 8'h22, 1, 0));
    tbl.push_back(mk(1, 8'h33, 1, 1, 8'h00, 8'h33, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 8'h55, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 8'hFF, 8'h00, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 8'hFF, 8'h00, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 8'hFF, 8'h00, 0, 0));
    tbl.push_back(mk(1, 8'hA1, 0, 0, 8'h00, 8'hAA, 1, 0));
    tbl.push_back(mk(1, 8'hA1, 0, 0, 8'h00, 8'hAA, 1, 0));
    tbl.push_back(mk(1, 8'hA1, 0, 1, 8'h00, 8'hA1, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 8'h00, 8'hA1, 1, 1));
    tbl.push_back(mk(0, 8'h00, 0, 1, 8'h00, 8'hA1, 1, 1));
    tbl.push_back(mk(1, 8'hB2, 1, 1, 8'h00, 8'hB2, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 8'h55, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 8'hFF, 8'h00, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 8'hFF, 8'h00, 0, 0));
    tbl.push_back(mk(1, 8'hC3, 1, 0, 8'h00, 8'hAA, 1, 0));
    tbl.push_back(mk(1, 8'hC3, 1, 0, 8'h00, 8'hAA, 1, 0));
    tbl.push_back(mk(1, 8'hC3, 1, 1, 8'h00, 8'hC3, 1, 0));
    tbl.push_back(mk(1, 8'hD4, 0, 0, 8'h00, 8'h55, 1, 0));
    tbl.push_back(mk(1, 8'hD4, 0, 0, 8'h00, 8'h00, 1, 0));
    tbl.push_back(mk(1, 8'hD4, 0, 0, 8'hFF, 8'h00, 1, 0));
    tbl.push_back(mk(1, 8'hD4, 0, 0, 8'hFF, 8'h00, 0, 0));
    tbl.push_back(mk(1, 8'hD4, 0, 0, 8'h00, 8'hAA, 1, 0));
    tbl.push_back(mk(1, 8'hD4, 0, 0, 8'h00, 8'hAA, 1, 0));
    tbl.push_back(mk(1, 8'hD4, 1, 1, 8'h00, 8'hD4, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 8'h55, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 8'hFF, 8'h00, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 8'hFF, 8'h00, 0, 0));

    h_q = '{8'hAA, 8'hAA, 8'hEE, 8'h00, 8'h00, 8'h00};
    h_t = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF};
    h_b = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    #3;
    do_reset();

    foreach (tbl[i]) begin
      s_valid = tbl[i].v; s_data = tbl[i].d; s_last = tbl[i].l;
      @(negedge clkin);
      #1;
      chk($sformatf("tbl%0d_t", i), out_t, tbl[i].t);
      chk($sformatf("tbl%0d_rdy", i), 8'(s_ready), 8'(tbl[i].rdy));
      @(posedge clkin);
      #1;
      chk($sformatf("tbl%0d_q", i), out_q, tbl[i].q);
      chk($sformatf("tbl%0d_busy", i), 8'(busy), 8'(tbl[i].b));
      chk($sformatf("tbl%0d_und", i), 8'(underrun), 8'(tbl[i].u));
    end

    // Asynchronous reset in the middle of DATA.
    cyc(1, 8'h10, 0);
    cyc(1, 8'h10, 0);
    cyc(1, 8'h10, 0);
    cyc(1, 8'h20, 0);
    chk("mid_q_before", out_q, 8'h20);
    chk("mid_busy_before", 8'(busy), 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_t", out_t, 8'hFF);
    chk("mid_rst_q", out_q, 8'h00);
    chk("mid_rst_busy", 8'(busy), 8'h00);
    s_valid = 0; s_data = 0; s_last = 0;
    @(negedge clkin);
    rst_n = 1'b1;
    @(posedge clkin);
    #1;
    chk("mid_rel_busy", 8'(busy), 8'h00);
    chk("mid_rel_q", out_q, 8'h00);
    cyc(1, 8'h30, 1);
    chk("mid_restart_q", out_q, 8'hAA);
    s_valid = 0;

    // Zero-length postamble instance: DATA goes straight to TURN.
    for (int k = 0; k < 6; k++) begin
      v0 = (k <= 2); d0 = 8'hEE; l0 = 1'b1;
      @(negedge clkin);
      #1;
      chk($sformatf("p0_%0d_t", k), t0, h_t[k]);
      chk($sformatf("p0_%0d_rdy", k), 8'(r0), 8'(k == 2));
      @(posedge clkin);
      #1;
      chk($sformatf("p0_%0d_q", k), q0, h_q[k]);
      chk($sformatf("p0_%0d_busy", k), 8'(b0), 8'(h_b[k]));
      chk($sformatf("p0_%0d_und", k), 8'(u0), 8'h00);
    end
    v0 = 0;

    // Random traffic against the timeline model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic       rv, rl;
      logic [7:0] rd;
      rv = ($urandom_range(0, 9) < 7);
      rd = 8'($urandom_range(0, 255));
      rl = ($urandom_range(0, 3) == 0);
      s_valid = rv; s_data = rd; s_last = rl;
      @(negedge clkin);
      #1;
      chk("rnd_rdy", 8'(s_ready), 8'(m_ready()));
      chk("rnd_t", out_t, m_t(rv));
      @(posedge clkin);
      m_step(rv, rd, rl);
      #1;
      chk("rnd_q", out_q, m_q());
      chk("rnd_busy", 8'(busy), 8'(in_b));
      chk("rnd_und", 8'(underrun), 8'(und_m));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
